// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the in-place radix-2 DIT FFT engine.
//   LOG2N / N  : default transform size (1024 points)
//   addr_t     : operand address type for the default size
//   stage_t    : stage index type for the default size
//   state_t    : sequencer state encoding
//   stage_w()  : width of a stage index for a given LOG2N
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N = 10;
    localparam int N     = 1 << LOG2N;

    // A one-stage transform would need a zero-width stage index; floor at 1 bit.
    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    typedef logic [LOG2N-1:0]          addr_t;
    typedef logic [stage_w(LOG2N)-1:0] stage_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_bf_addr_gen
// Combinational butterfly address generator for stage s, butterfly k.
//   s_i       : stage index
//   k_i       : butterfly index within the stage (0 .. N/2-1)
//   addr_a_o  : upper-wing operand address  (grp << (s+1)) | pos
//   addr_b_o  : lower-wing operand address  addr_a + (1 << s)
//   tw_addr_o : twiddle ROM index           pos << (LOG2N-1-s)
// where pos = k & ((1<<s)-1) and grp = k >> s. LOG2N must be at least 2.
// ----------------------------------------------------------------------------
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int SW    = fft_pkg::stage_w(LOG2N)
) (
    input  logic [SW-1:0]    s_i,
    input  logic [LOG2N-2:0] k_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_addr_o
);

    logic [LOG2N-1:0] k_ext_s;
    logic [LOG2N-1:0] half_s;
    logic [LOG2N-1:0] pos_s;
    logic [LOG2N-1:0] grp_s;
    logic [SW:0]      sh_a_s;
    logic [SW:0]      sh_tw_s;

    // Address and twiddle derivation; pos < half so the twiddle never overflows LOG2N-1 bits.
    always_comb begin
        k_ext_s   = {1'b0, k_i};
        half_s    = {{(LOG2N-1){1'b0}}, 1'b1} << s_i;
        pos_s     = k_ext_s & (half_s - {{(LOG2N-1){1'b0}}, 1'b1});
        grp_s     = k_ext_s >> s_i;
        sh_a_s    = {1'b0, s_i} + {{SW{1'b0}}, 1'b1};
        sh_tw_s   = (SW+1)'(LOG2N-1) - {1'b0, s_i};
        addr_a_o  = (grp_s << sh_a_s) | pos_s;
        addr_b_o  = addr_a_o + half_s;
        tw_addr_o = pos_s[LOG2N-2:0] << sh_tw_s;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// ----------------------------------------------------------------------------
// fft_stage_sequencer
// Walks every stage and butterfly of an N-point in-place radix-2 DIT FFT and
// issues one butterfly command per valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a transform (only honoured in IDLE)
//   busy, done        : transform in progress / one-cycle completion pulse
//   bf_valid/bf_ready : butterfly command handshake
//   addr_a, addr_b    : operand addresses; tw_addr : twiddle index
//   stage             : current stage; last : final butterfly of final stage
// Build option FFT_SEQ_DRAIN_EN: insert PIPE_LAT idle cycles after every stage
// (including the last) so the datapath writes back before the next stage reads.
// PIPE_LAT must be at least 1 when the drain is built in.
// ----------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter  int LOG2N    = fft_pkg::LOG2N,
    parameter  int PIPE_LAT = 4,
    localparam int SW       = fft_pkg::stage_w(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic [SW-1:0]    stage,
    output logic             last
);

    localparam int            KW     = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};   // N/2-1
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic            busy_d;
    logic            done_d;
    logic            run_d_s;
    logic [LOG2N-1:0] gen_a_s;
    logic [LOG2N-1:0] gen_b_s;
    logic [LOG2N-2:0] gen_tw_s;

`ifdef FFT_SEQ_DRAIN_EN
    localparam int            CW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PIPE_LAT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int unused_pipe_lat = PIPE_LAT;
`endif

    // Addresses are generated from the next-state counters so they can be registered.
    fft_bf_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .s_i       (s_d),
        .k_i       (k_d),
        .addr_a_o  (gen_a_s),
        .addr_b_o  (gen_b_s),
        .tw_addr_o (gen_tw_s)
    );

    // Next-state logic: stage/butterfly counters, drain counter and status flags.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef FFT_SEQ_DRAIN_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bf_valid && bf_ready) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
`ifdef FFT_SEQ_DRAIN_EN
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
`else
                        if (s_q == S_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            s_d = s_q + {{(SW-1){1'b0}}, 1'b1};
                        end
`endif
                    end else begin
                        k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ST_DRAIN: begin
`ifdef FFT_SEQ_DRAIN_EN
                if (cnt_q == CNT_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + {{(SW-1){1'b0}}, 1'b1};
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                k_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
        run_d_s = (state_d == ST_RUN);
    end

    // State and output registers; command outputs read zero outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bf_valid <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            tw_addr  <= '0;
            last     <= 1'b0;
`ifdef FFT_SEQ_DRAIN_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            busy     <= busy_d;
            done     <= done_d;
            bf_valid <= run_d_s;
            addr_a   <= run_d_s ? gen_a_s  : '0;
            addr_b   <= run_d_s ? gen_b_s  : '0;
            tw_addr  <= run_d_s ? gen_tw_s : '0;
            last     <= run_d_s && (s_d == S_LAST) && (k_d == K_LAST);
`ifdef FFT_SEQ_DRAIN_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign stage = s_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Directed bench: an 8-point instance (LOG2N=3, PIPE_LAT=2) checked command by
// command against a hand-derived table, plus a default 1024-point instance
// checked for transfer count, final command and completion time.
// Expected timing follows the FFT_SEQ_DRAIN_EN build option.
// ----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

`ifdef FFT_SEQ_DRAIN_EN
    localparam int DRAIN = 1;
`else
    localparam int DRAIN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start3, ready3, busy3, done3, valid3, last3;
    logic [2:0] a3, b3;
    logic [1:0] tw3;
    logic [1:0] stg3;
    logic       start10, ready10, busy10, done10, valid10, last10;
    logic [9:0] a10, b10;
    logic [8:0] tw10;
    logic [3:0] stg10;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk = ~clk;

    fft_stage_sequencer #(.LOG2N(3), .PIPE_LAT(2)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .bf_valid(valid3), .bf_ready(ready3), .addr_a(a3), .addr_b(b3),
        .tw_addr(tw3), .stage(stg3), .last(last3)
    );

    fft_stage_sequencer dut10 (
        .clk(clk), .rst(rst), .start(start10), .busy(busy10), .done(done10),
        .bf_valid(valid10), .bf_ready(ready10), .addr_a(a10), .addr_b(b10),
        .tw_addr(tw10), .stage(stg10), .last(last10)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Run one 8-point transform; optionally stall one command or poke start while busy.
    task automatic run8(input int stall_idx, input int stall_n, input bit poke);
        int idx = 0;
        int stalls = 0;
        int n_done = 0;
        int done_cyc = 0;
        int n_last = 0;
        int busy_bad = 0;
        int extra = 0;
        int pres [12];
        for (int i = 0; i < 12; i++) pres[i] = 0;
        @(negedge clk);
        start3 = 1'b1;
        ready3 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start3 = (poke && (c == 3 || c == 6)) ? 1'b1 : 1'b0;
            if (done3) begin
                n_done++;
                done_cyc = c;
            end
            if (busy3 !== ((done_cyc == 0 || c <= done_cyc) ? 1'b1 : 1'b0)) busy_bad++;
            if (last3) n_last++;
            if (valid3) begin
                if (idx < 12) begin
                    if (pres[idx] == 0) pres[idx] = c;
                    check($sformatf("addr_a[%0d]", idx), int'(a3), exp_a[idx]);
                    check($sformatf("addr_b[%0d]", idx), int'(b3), exp_b[idx]);
                    check($sformatf("tw[%0d]", idx), int'(tw3), exp_tw[idx]);
                    check($sformatf("stage[%0d]", idx), int'(stg3), idx / 4);
                    check($sformatf("last[%0d]", idx), int'(last3), (idx == 11) ? 1 : 0);
                end else begin
                    extra++;
                end
                if (idx == stall_idx && stalls < stall_n) begin
                    ready3 = 1'b0;
                    stalls++;
                end else begin
                    ready3 = 1'b1;
                    idx++;
                end
            end else begin
                ready3 = 1'b1;
            end
        end
        check("transfers", idx, 12);
        check("extra_cmds", extra, 0);
        check("done_pulses", n_done, 1);
        check("done_cycle", done_cyc, 13 + DRAIN * 3 * 2 + stall_n);
        check("last_count", n_last, 1);
        check("busy_window", busy_bad, 0);
        check("stage_gap", pres[4] - pres[3], 1 + DRAIN * 2);
        check("first_cmd_cycle", pres[0], 1);
        if (stall_n > 0) check("stall_hold", pres[stall_idx + 1] - pres[stall_idx], stall_n + 1);
    endtask

    initial begin
        int n_xfer;
        int n_done;
        int n_last;
        int done_cyc;
        int la, lb, ltw, lstg;

        rst = 1'b1; start3 = 1'b0; ready3 = 1'b1; start10 = 1'b0; ready10 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy3), 0);
        check("rst_done", int'(done3), 0);
        check("rst_valid", int'(valid3), 0);
        check("rst_addr", int'({a3, b3, tw3, stg3, last3}), 0);
        check("rst_busy10", int'(busy10), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain sequence, ready held high.
        run8(-1, 0, 1'b0);
        // Backpressure on the second command.
        run8(1, 3, 1'b0);
        // start pulsed while busy must be ignored.
        run8(-1, 0, 1'b1);

        // Reset mid-transform (stage 1), then a clean replay.
        @(negedge clk);
        start3 = 1'b1;
        ready3 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start3 = 1'b0;
        end
        check("pre_rst_stage", int'(stg3), 1);
        check("pre_rst_valid", int'(valid3), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", int'(busy3), 0);
        check("mid_rst_valid", int'(valid3), 0);
        check("mid_rst_outs", int'({a3, b3, tw3, stg3, last3, done3}), 0);
        n_xfer = 0;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid3) n_xfer++;
            if (done3 || busy3) n_done++;
        end
        check("post_rst_cmds", n_xfer, 0);
        check("post_rst_activity", n_done, 0);
        run8(-1, 0, 1'b0);

        // Default 1024-point transform.
        n_xfer = 0; n_done = 0; n_last = 0; done_cyc = 0;
        la = 0; lb = 0; ltw = 0; lstg = 0;
        @(negedge clk);
        start10 = 1'b1;
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk);
            start10 = 1'b0;
            if (valid10) begin
                n_xfer++;
                la = int'(a10); lb = int'(b10); ltw = int'(tw10); lstg = int'(stg10);
            end
            if (last10) n_last++;
            if (last10 && !valid10) n_last += 100;
            if (done10) begin
                n_done++;
                done_cyc = c;
            end
        end
        check("n1024_transfers", n_xfer, 5120);
        check("n1024_final_a", la, 511);
        check("n1024_final_b", lb, 1023);
        check("n1024_final_tw", ltw, 511);
        check("n1024_final_stage", lstg, 9);
        check("n1024_last_count", n_last, 1);
        check("n1024_done_pulses", n_done, 1);
        check("n1024_done_cycle", done_cyc, 5121 + DRAIN * 10 * 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequencer for the in-place radix-2 DIT FFT engine. After `start`, it walks every stage and every butterfly of an N-point transform and issues one butterfly command per handshake to the shared butterfly datapath. Each command carries the two operand addresses and the twiddle address. It sits between the top-level FFT control and the butterfly/memory datapath, and is the only master of the butterfly command port.

## Interface
Parameters:
- `LOG2N`, default 10: log2 of transform size; N = 1024.
- `PIPE_LAT`, default 4: butterfly read-to-writeback latency in cycles, used for the inter-stage drain.

Ports:
- `clk`, in, 1: the single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a transform; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after accepted `start` until `done`, inclusive.
- `done`, out, 1: one-cycle pulse when the transform completes.
- `bf_valid`, out, 1: butterfly command valid.
- `bf_ready`, in, 1: datapath accepts the command.
- `addr_a`, out, `addr_t` (LOG2N bits): upper-wing operand address.
- `addr_b`, out, `addr_t`: lower-wing operand address.
- `tw_addr`, out, LOG2N-1 bits: twiddle ROM index.
- `stage`, out, `stage_t` (clog2(LOG2N) bits): current stage.
- `last`, out, 1: marks the final butterfly of the final stage; qualified by `bf_valid`.

## Operation
- States: IDLE, RUN, DRAIN, DONE; the state type is an enum.
- Reset: state IDLE; all outputs 0; the stage counter s = 0 and butterfly counter k = 0.
- IDLE:
  - `start`=1 → RUN with s=0, k=0.
  - `start` is ignored in every other state.
- RUN:
  - `bf_valid`=1.
  - Address and twiddle derivation, with half = 1<<s, pos = k & (half-1), grp = k >> s:
    - addr_a = (grp << (s+1)) | pos
    - addr_b = addr_a + half
    - tw_addr = pos << (LOG2N-1-s)
  - Width rule: all arithmetic is LOG2N bits with no overflow; addr_b never exceeds N-1.
  - Transfer occurs when `bf_valid && bf_ready`. On transfer, k increments.
  - While `bf_ready`=0, all command outputs hold stable.
- End of stage: the transfer with k = N/2-1.
  - If s < LOG2N-1: go to DRAIN (or straight to RUN with s+1 and k=0 when drain is compiled out).
  - If s = LOG2N-1: go to DRAIN (or DONE when drain is compiled out).
- DRAIN:
  - `bf_valid`=0.
  - Counts PIPE_LAT cycles, then goes to RUN with s+1 and k=0, or to DONE after the final stage.
- DONE: `done`=1 for one cycle, then IDLE.
- `last` = 1 exactly when s = LOG2N-1 and k = N/2-1.
- `rst` mid-transform returns to IDLE immediately. No further commands are issued and `done` is not pulsed.

## Timing
- `start` sampled at edge t → `bf_valid`=1 with the first command from cycle t+1.
- All outputs are registered; there is no combinational path from `bf_ready` to any output.
- Continuous `bf_ready`=1 gives one command per cycle.
- Total transfers: (N/2)·LOG2N.
- Drain enabled, ready held high, total cycles from `start` to `done`: (N/2)·LOG2N + LOG2N·PIPE_LAT + 1.
- `busy` falls the cycle after `done`.

## Configuration
- `FFT_SEQ_DRAIN_EN` defined:
  - DRAIN state and its counter exist.
  - PIPE_LAT idle cycles are inserted after every stage, including the last, to avoid read-after-write hazards.
- `FFT_SEQ_DRAIN_EN` undefined:
  - DRAIN and its counter are removed.
  - The next stage's first command follows the previous stage's last transfer on the next cycle.
  - After the final stage, DONE follows directly.
  - PIPE_LAT is unused.

## Structure
- Shared package `fft_pkg` holds:
  - `addr_t`, which is `logic [9:0]` for the default LOG2N
  - `stage_t`
  - the state enum
  - the constants LOG2N and N
- One sub-module, `fft_bf_addr_gen`:
  - purely combinational
  - inputs s, k
  - outputs addr_a, addr_b, tw_addr
  - its outputs are registered in the sequencer

## Test plan
- LOG2N=3, drain on, PIPE_LAT=2, ready always 1, with (a,b,tw) listed per command:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - 12 transfers; `last` on (3,7,3); `done` 19 cycles after `start`.
- Backpressure: `bf_ready` low for 3 cycles on the 2nd command → (2,3,0) is held stable for those 3 cycles; the sequence is otherwise identical.
- `start` pulsed while busy → ignored; exactly 12 transfers and one `done`.
- `rst` asserted during stage 1 → next cycle all outputs 0, state IDLE, no `done`; a new `start` replays from (0,1,0).
- Drain compiled out, LOG2N=3 → (0,2,0) is issued the cycle after (6,7,0); `done` 13 cycles after `start`.
- Default LOG2N=10 → 5120 transfers; final command is (511,1023,511) with `last`=1.
